// File: rtl/zr_cfg_pkg.sv
// Shared Zero_Risc control-flow table constants: branch record layout and the
// default instruction stride, common to the recorder and the integrity checker.
package zr_cfg_pkg;

    localparam int ZR_REC_W    = 32;
    localparam int ZR_ADDR_W   = 16;
    localparam int ZR_FROM_MSB = 31;
    localparam int ZR_FROM_LSB = 16;
    localparam int ZR_TO_MSB   = 15;
    localparam int ZR_TO_LSB   = 0;
    localparam int ZR_STRIDE   = 4;

    typedef logic [ZR_REC_W-1:0] zr_rec_t;

    function automatic zr_rec_t zr_make_rec(input logic [ZR_ADDR_W-1:0] from_addr,
                                            input logic [ZR_ADDR_W-1:0] to_addr);
        zr_rec_t rec;
        rec = '0;
        rec[ZR_FROM_MSB:ZR_FROM_LSB] = from_addr;
        rec[ZR_TO_MSB:ZR_TO_LSB]     = to_addr;
        return rec;
    endfunction

endpackage

// File: rtl/cfg_rec_fifo.sv
// Show-ahead record FIFO with wrap-bit pointers and a registered occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module cfg_rec_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       not_empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             empty;
    logic             do_pop;
    logic             do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign not_empty = !empty;
    // Masked while empty so the head reads 0 after reset without clearing storage.
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers define what is valid,
    // and leaving the array reset-free lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cfg_branch_recorder.sv
// Branch recorder: turns non-sequential PC transitions into {from,to} table records.
// Optional duplicate suppression is built when CFG_REC_DEDUP_EN is defined.
module cfg_branch_recorder
    import zr_cfg_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int STRIDE    = ZR_STRIDE,
    parameter int SEEN_SIZE = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_enable,
    input  logic [31:0]                i_instr_addr,
    output logic [ZR_REC_W-1:0]        o_rec_data,
    output logic                       o_rec_valid,
    input  logic                       i_rec_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow
);

    logic [31:0]   pc_last;
    logic          pc_valid;
    logic [31:0]   pc_seq;
    logic          addr_moved;
    logic          branch;
    zr_rec_t       rec;
    logic          seen_hit;
    logic          fifo_full;
    logic          pop;
    logic          room;
    logic          push;
    logic          drop;

    assign pc_seq     = pc_last + 32'(STRIDE);
    // Address 0 marks an empty table slot, so it never moves the tracker.
    assign addr_moved = (i_instr_addr != pc_last) && (i_instr_addr != '0);
    assign branch     = addr_moved && pc_valid && i_enable && (i_instr_addr != pc_seq);
    assign rec        = zr_make_rec(pc_last[ZR_ADDR_W-1:0], i_instr_addr[ZR_ADDR_W-1:0]);

    assign pop  = o_rec_valid && i_rec_ready;
    assign room = !fifo_full || pop;
    assign push = branch && !seen_hit && room;
    assign drop = branch && !seen_hit && !room;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_last  <= '0;
            pc_valid <= 1'b0;
        end else if (addr_moved) begin
            pc_last  <= i_instr_addr;
            pc_valid <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)      o_overflow <= 1'b0;
        else if (drop)  o_overflow <= 1'b1;
    end

`ifdef CFG_REC_DEDUP_EN
    localparam int SW = (SEEN_SIZE > 1) ? $clog2(SEEN_SIZE) : 1;

    zr_rec_t                seen_rec [SEEN_SIZE];
    logic [SEEN_SIZE-1:0]   seen_vld;
    logic [SW-1:0]          seen_ptr;

    // NOTE: the flag gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        seen_hit = 1'b0;
        for (int i = 0; i < SEEN_SIZE; i++) begin
            if (seen_vld[i] && (seen_rec[i] == rec)) seen_hit = 1'b1;
        end
    end

    // Only records actually queued enter the history; dropped misses do not.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            seen_vld <= '0;
            seen_ptr <= '0;
        end else if (push) begin
            seen_vld[seen_ptr] <= 1'b1;
            seen_ptr <= (seen_ptr == SW'(SEEN_SIZE - 1)) ? '0 : seen_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) seen_rec[seen_ptr] <= rec;
    end
`else
    assign seen_hit = 1'b0;
`endif

    cfg_rec_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ZR_REC_W)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (push),
        .push_data (rec),
        .pop       (pop),
        .head_data (o_rec_data),
        .not_empty (o_rec_valid),
        .full      (fifo_full),
        .count     (o_count)
    );

endmodule

// File: tb/tb_cfg_branch_recorder.sv
// Scoreboard bench for cfg_branch_recorder: a queue-based reference model predicts
// every record; a negedge monitor compares pops, occupancy, valid and overflow.
module tb_cfg_branch_recorder;

    localparam int DEPTH     = 8;
    localparam int STRIDE    = 4;
    localparam int SEEN_SIZE = 16;
    localparam int CW        = $clog2(DEPTH + 1);

    logic          i_clk        = 1'b0;
    logic          i_rst        = 1'b1;
    logic          i_enable     = 1'b0;
    logic [31:0]   i_instr_addr = '0;
    logic          i_rec_ready  = 1'b0;
    logic [31:0]   o_rec_data;
    logic          o_rec_valid;
    logic [CW-1:0] o_count;
    logic          o_overflow;

    always #5 i_clk = ~i_clk;

    cfg_branch_recorder #(
        .DEPTH     (DEPTH),
        .STRIDE    (STRIDE),
        .SEEN_SIZE (SEEN_SIZE)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_enable     (i_enable),
        .i_instr_addr (i_instr_addr),
        .o_rec_data   (o_rec_data),
        .o_rec_valid  (o_rec_valid),
        .i_rec_ready  (i_rec_ready),
        .o_count      (o_count),
        .o_overflow   (o_overflow)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference model state (after all edges issued so far) and a snapshot of
    // the state after the most recent edge, which is what the DUT shows now.
    logic [31:0] m_pc    = '0;
    bit          m_pcv   = 1'b0;
    int          m_count = 0;
    bit          m_ovf   = 1'b0;
    int          cur_count = 0;
    bit          cur_ovf   = 1'b0;
    logic [31:0] exp_q  [$];
    logic [31:0] seen_q [$];
    bit          mon_on    = 1'b0;
    logic [31:0] watch_rec = '0;
    int          rec_hits  = 0;

    task automatic model_edge(input logic [31:0] addr, input bit en, input bit rdy, input bit rst);
        bit          pop;
        bit          dup;
        logic [31:0] r;
        if (rst) begin
            m_pc = '0; m_pcv = 1'b0; m_count = 0; m_ovf = 1'b0;
            exp_q.delete();
            seen_q.delete();
            return;
        end
        pop = (m_count > 0) && rdy;
        if (addr != 0 && addr != m_pc) begin
            if (m_pcv && en && addr != m_pc + 32'(STRIDE)) begin
                r   = {m_pc[15:0], addr[15:0]};
                dup = 1'b0;
`ifdef CFG_REC_DEDUP_EN
                foreach (seen_q[i]) if (seen_q[i] == r) dup = 1'b1;
`endif
                if (!dup) begin
                    if (m_count < DEPTH || pop) begin
                        exp_q.push_back(r);
                        m_count++;
`ifdef CFG_REC_DEDUP_EN
                        seen_q.push_back(r);
                        if (seen_q.size() > SEEN_SIZE) void'(seen_q.pop_front());
`endif
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            m_pc  = addr;
            m_pcv = 1'b1;
        end
        if (pop) m_count--;
    endtask

    task automatic step(input logic [31:0] addr, input bit en, input bit rdy, input bit rst = 1'b0);
        @(posedge i_clk);
        #2;
        cur_count    = m_count;
        cur_ovf      = m_ovf;
        i_instr_addr = addr;
        i_enable     = en;
        i_rec_ready  = rst ? 1'b0 : rdy;
        i_rst        = rst;
        model_edge(addr, en, rst ? 1'b0 : rdy, rst);
    endtask

    task automatic hold(input int n, input bit rdy);
        for (int k = 0; k < n; k++) step(m_pc, 1'b1, rdy);
    endtask

    task automatic at_neg();
        @(negedge i_clk);
        #1;
    endtask

    // Monitor: inputs are stable at the negedge, so valid && ready here means
    // the head record is consumed at the next rising edge.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge i_clk);
            if (mon_on) begin
                check("count", 32'(o_count), 32'(cur_count));
                check("valid", 32'(o_rec_valid), 32'(cur_count != 0));
                check("overflow", 32'(o_overflow), 32'(cur_ovf));
                if (o_rec_valid && i_rec_ready && !i_rst) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_record: got %h, expected no record", o_rec_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("rec_data", o_rec_data, e);
                        if (o_rec_data == watch_rec) rec_hits++;
                    end
                end
            end
        end
    end

    initial begin
        int          r;
        logic [31:0] a;
        logic [31:0] pool [8];
        pool = '{32'h0000_0100, 32'h0000_0180, 32'h0000_0200, 32'h0000_0458,
                 32'h0000_1000, 32'hFFFF_FFFC, 32'h0001_0100, 32'h0000_2000};

        step(32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        mon_on = 1'b1;
        step(32'h0, 1'b1, 1'b0);
        at_neg();
        check("reset_valid", 32'(o_rec_valid), 32'h0);
        check("reset_data", o_rec_data, 32'h0);
        check("reset_count", 32'(o_count), 32'h0);

        // Sequential run: no records.
        step(32'h100, 1'b1, 1'b1);
        step(32'h104, 1'b1, 1'b1);
        step(32'h108, 1'b1, 1'b1);
        step(32'h10C, 1'b1, 1'b1);
        hold(2, 1'b1);
        at_neg();
        check("seq_no_valid", 32'(o_rec_valid), 32'h0);

        // Single jump: 0x1D8 -> 0x45C, visible one cycle after sampling.
        step(32'h1D4, 1'b0, 1'b0);
        step(32'h1D8, 1'b1, 1'b0);
        step(32'h45C, 1'b1, 1'b0);
        hold(1, 1'b0);
        at_neg();
        check("jump_valid", 32'(o_rec_valid), 32'h1);
        check("jump_data", o_rec_data, 32'h01D8_045C);
        hold(1, 1'b1);
        hold(1, 1'b0);
        at_neg();
        check("jump_pop_count", 32'(o_count), 32'h0);

        // Stall and zero address: no record until the real jump.
        step(32'h200, 1'b0, 1'b0);
        step(32'h200, 1'b1, 1'b0);
        step(32'h200, 1'b1, 1'b0);
        step(32'h000, 1'b1, 1'b0);
        step(32'h204, 1'b1, 1'b0);
        hold(1, 1'b0);
        at_neg();
        check("stall_zero_count", 32'(o_count), 32'h0);
        step(32'h180, 1'b1, 1'b0);
        hold(1, 1'b0);
        at_neg();
        check("stall_jump_data", o_rec_data, 32'h0204_0180);
        hold(2, 1'b1);

        // Overflow: nine distinct jumps with the consumer stalled.
        step(32'h0, 1'b0, 1'b0, 1'b1);
        step(32'h1000, 1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) step(32'h1000 + 32'(k) * 32'h40, 1'b1, 1'b0);
        hold(1, 1'b0);
        at_neg();
        check("ovf_count", 32'(o_count), 32'd8);
        check("ovf_flag", 32'(o_overflow), 32'h1);
        step(32'h2000, 1'b1, 1'b1);
        hold(1, 1'b0);
        at_neg();
        check("full_push_pop_count", 32'(o_count), 32'd8);
        hold(10, 1'b1);
        at_neg();
        check("ovf_drained", 32'(o_count), 32'h0);
        check("ovf_sticky", 32'(o_overflow), 32'h1);

        // Reset mid-operation with four queued records.
        step(32'h3000, 1'b1, 1'b0);
        step(32'h3100, 1'b1, 1'b0);
        step(32'h3200, 1'b1, 1'b0);
        step(32'h3300, 1'b1, 1'b0);
        hold(1, 1'b0);
        at_neg();
        check("pre_reset_count", 32'(o_count), 32'd4);
        step(32'h3300, 1'b1, 1'b0, 1'b1);
        step(32'h5000, 1'b1, 1'b0);
        hold(1, 1'b0);
        at_neg();
        check("rst_valid", 32'(o_rec_valid), 32'h0);
        check("rst_count", 32'(o_count), 32'h0);
        check("rst_overflow", 32'(o_overflow), 32'h0);

        // Repeated jump 0x0458 -> 0x0180 three times.
        step(32'h0, 1'b0, 1'b0, 1'b1);
        watch_rec = 32'h0458_0180;
        rec_hits  = 0;
        for (int k = 0; k < 3; k++) begin
            step(32'h458, 1'b1, 1'b1);
            step(32'h180, 1'b1, 1'b1);
        end
        hold(6, 1'b1);
`ifdef CFG_REC_DEDUP_EN
        check("dedup_hits", 32'(rec_hits), 32'd1);
`else
        check("dedup_hits", 32'(rec_hits), 32'd3);
`endif
        watch_rec = '0;

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 3)      a = (m_pc == 0) ? pool[$urandom_range(0, 7)] : m_pc + 32'(STRIDE);
            else if (r == 4) a = m_pc;
            else if (r == 5) a = '0;
            else             a = pool[$urandom_range(0, 7)];
            step(a, $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 149) == 0);
        end
        hold(DEPTH + 4, 1'b1);
        at_neg();
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        check("final_count", 32'(o_count), 32'h0);

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
